// File: rtl/si_quant_pkg.sv
// Shared types and arithmetic helpers for the quantized neuron datapath.
// Used by the MAC stage here and by later layer blocks.
package si_quant_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int SI_N_ACC = 32;

    localparam logic signed [SI_N_ACC-1:0] SAT_MAX = {1'b0, {(SI_N_ACC-1){1'b1}}};
    localparam logic signed [SI_N_ACC-1:0] SAT_MIN = {1'b1, {(SI_N_ACC-1){1'b0}}};

    typedef struct packed {
        logic signed [SI_N_ACC-1:0] sum;
        logic                       sat;
    } sat_sum_t;

    // One guard bit: when the top two bits of the wide sum differ, the result left the range.
    function automatic sat_sum_t sat_add(input logic signed [SI_N_ACC-1:0] a,
                                         input logic signed [SI_N_ACC-1:0] b);
        logic [SI_N_ACC:0] full;
        sat_sum_t          r;
        full = {a[SI_N_ACC-1], a} + {b[SI_N_ACC-1], b};
        if (full[SI_N_ACC] != full[SI_N_ACC-1]) begin
            r.sat = 1'b1;
            r.sum = full[SI_N_ACC] ? SAT_MIN : SAT_MAX;
        end else begin
            r.sat = 1'b0;
            r.sum = full[SI_N_ACC-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/si_mpy.sv
// W-bit multiplier keeping the low W bits; exact when operands were sign-extended
// from W/2 bits, since the full signed product then fits in W bits.
module si_mpy #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] p_o
);

    assign p_o = a_i * b_i;

endmodule

// File: rtl/si_upscaler.sv
// Sign-extends a signed operand from N_IN to N_OUT bits.
module si_upscaler #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 16
) (
    input  logic signed [N_IN-1:0]  in_i,
    output logic signed [N_OUT-1:0] out_o
);

    assign out_o = {{(N_OUT-N_IN){in_i[N_IN-1]}}, in_i};

endmodule

// File: rtl/si_mac_accumulator.sv
// Sequential multiply-accumulate for one quantized neuron: N_TERMS products summed
// onto BIAS with saturation, valid/ready on both sides.
module si_mac_accumulator
    import si_quant_pkg::*;
#(
    parameter int                       N_IN    = 8,
    parameter int                       N_ACC   = SI_N_ACC,
    parameter int                       N_TERMS = 16,
    parameter logic signed [N_ACC-1:0]  BIAS    = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [N_IN-1:0]  in_a,
    input  logic signed [N_IN-1:0]  in_w,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [N_ACC-1:0] out_acc,
    output logic                    out_sat
);

    localparam int PW    = 2 * N_IN;
    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    state_e                  state_q, state_d;
    logic signed [N_ACC-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sat_q, sat_d;

    logic signed [PW-1:0]    a_ext_s, w_ext_s, prod_s;
    logic signed [N_ACC-1:0] prod_ext_s;
    sat_sum_t                add_s;

    si_upscaler #(.N_IN(N_IN), .N_OUT(PW)) u_up_a (.in_i(in_a), .out_o(a_ext_s));
    si_upscaler #(.N_IN(N_IN), .N_OUT(PW)) u_up_w (.in_i(in_w), .out_o(w_ext_s));
    si_mpy      #(.W(PW))                  u_mpy  (.a_i(a_ext_s), .b_i(w_ext_s), .p_o(prod_s));

    assign prod_ext_s = {{(N_ACC-PW){prod_s[PW-1]}}, prod_s};

    // Next-state logic: FSM, accumulator, beat counter and sticky saturation flag.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        add_s   = sat_add(acc_q, prod_ext_s);
        case (state_q)
            IDLE: begin
                state_d = ACCUM;
                acc_d   = BIAS;
                cnt_d   = '0;
                sat_d   = 1'b0;
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = add_s.sum;
                    sat_d = sat_q | add_s.sat;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    acc_d   = BIAS;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out_acc   = acc_q;
    assign out_sat   = sat_q;

endmodule
